proc_input_arbiter: RTL and testbench

PROC_INPUT_ARBITER -- requirements
Module: proc_input_arbiter

---
 rtl/proc_input_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_proc_input_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : proc_input_arbiter
// Purpose  : Round-robin read issuer over three input memory pages per event.
//            Optional cycle budget: define PROC_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module proc_input_arbiter #(
    parameter int MEM_SIZE = 6,
    parameter int TIMEOUT  = 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_proc,
    input  logic [1:0]          start,
    input  logic [5:0]          number_in_1,
    input  logic [5:0]          number_in_2,
    input  logic [5:0]          number_in_3,
    output logic [MEM_SIZE+1:0] read_add_1,
    output logic [MEM_SIZE+1:0] read_add_2,
    output logic [MEM_SIZE+1:0] read_add_3,
    output logic                rd_en_1,
    output logic                rd_en_2,
    output logic                rd_en_3,
    output logic [1:0]          sel,
    output logic                valid,
    output logic [1:0]          done,
    output logic                busy,
    output logic                truncated
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]                r_start_q;
    logic [1:0]                r_page;
    logic [1:0]                r_last;
    logic [1:0]                r_sel;
    logic [1:0]                r_done;
    logic                      r_valid;
    logic [1:0]                w_grant;
    logic [1:0]                w_src;
    logic                      w_start_chg;
    logic                      w_issue;
    logic                      w_exhausted;
    logic                      w_timeout_hit;
    logic                      w_trunc_go;
    logic                      w_done_upd;
    logic [3:1]                w_nz;
    logic [3:1]                w_left;
    logic [3:1]                w_rd;
    logic [3:1][5:0]           w_num;
    logic [3:1][MEM_SIZE+1:0]  w_addr;

    assign w_num       = {number_in_3, number_in_2, number_in_1};
    assign w_start_chg = (start != r_start_q);
    assign w_issue     = (r_state == S_RUN) && !w_start_chg && en_proc && (w_grant != 2'd0);
    assign w_exhausted = (w_left == 3'b000);

    // Search order begins one past the last granted source; r_last = 0 means none yet.
    always_comb begin
        w_grant = 2'd0;
        w_src   = 2'd0;
        for (int k = 0; k < 3; k++) begin
            w_src = 2'(((int'(r_last) + k) % 3) + 1);
            if ((w_grant == 2'd0) && w_nz[w_src]) begin
                w_grant = w_src;
            end
        end
    end

    for (genvar n = 1; n <= 3; n++) begin : g_src
        logic [5:0]          r_rem;
        logic [MEM_SIZE-1:0] r_idx;
        logic [MEM_SIZE+1:0] r_addr;
        logic                r_rd;
        logic                w_hit;

        assign w_hit     = w_issue && (w_grant == 2'(n));
        assign w_nz[n]   = (r_rem != 6'd0);
        assign w_left[n] = (r_rem > {5'd0, w_hit});
        assign w_rd[n]   = r_rd;
        assign w_addr[n] = r_addr;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_rem  <= 6'd0;
                r_idx  <= '0;
                r_addr <= '0;
                r_rd   <= 1'b0;
            end else begin
                r_rd <= w_hit;
                if (w_hit) begin
                    r_addr <= {r_page, r_idx};
                end
                if (w_start_chg) begin
                    r_rem <= w_num[n];
                    r_idx <= '0;
                end else if (w_trunc_go) begin
                    r_rem <= 6'd0;
                end else if (w_hit) begin
                    r_rem <= r_rem - 6'd1;
                    r_idx <= r_idx + MEM_SIZE'(1);
                end
            end
        end
    end

`ifdef PROC_ARB_TIMEOUT_EN
    localparam int c_CW = $clog2(TIMEOUT + 1);

    logic [c_CW-1:0] r_cyc;
    logic            r_trunc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cyc   <= '0;
            r_trunc <= 1'b0;
        end else begin
            r_trunc <= w_trunc_go;
            if (w_start_chg) begin
                r_cyc <= '0;
            end else if ((r_state == S_RUN) && en_proc) begin
                r_cyc <= r_cyc + c_CW'(1);
            end
        end
    end

    assign w_timeout_hit = (r_state == S_RUN) && en_proc && (r_cyc == c_CW'(TIMEOUT - 1));
    assign truncated     = r_trunc;
`else
    // Without the budget an event never times out; TIMEOUT has no effect.
    assign w_timeout_hit = (TIMEOUT < 0);
    assign truncated     = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_trunc_go  = 1'b0;
        w_done_upd  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_chg) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_start_chg) begin
                    w_done_upd  = 1'b1;
                    w_state_nxt = S_RUN;
                end else if (w_exhausted) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_timeout_hit) begin
                    w_state_nxt = S_DRAIN;
                    w_trunc_go  = 1'b1;
                end
            end
            S_DRAIN: begin
                w_done_upd  = 1'b1;
                w_state_nxt = w_start_chg ? S_RUN : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_q <= 2'd0;
            r_page    <= 2'd0;
            r_last    <= 2'd0;
            r_done    <= 2'd0;
            r_valid   <= 1'b0;
            r_sel     <= 2'd0;
        end else begin
            r_start_q <= start;
            if (w_start_chg) begin
                r_page <= start;
                r_last <= 2'd0;
            end else if (w_issue) begin
                r_last <= w_grant;
            end
            if (w_done_upd) r_done <= r_page;
            r_valid <= |w_rd;
            r_sel   <= w_rd[1] ? 2'd1 : (w_rd[2] ? 2'd2 : (w_rd[3] ? 2'd3 : 2'd0));
        end
    end

    assign read_add_1 = w_addr[1];
    assign read_add_2 = w_addr[2];
    assign read_add_3 = w_addr[3];
    assign rd_en_1    = w_rd[1];
    assign rd_en_2    = w_rd[2];
    assign rd_en_3    = w_rd[3];
    assign sel        = r_sel;
    assign valid      = r_valid;
    assign done       = r_done;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_proc_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_input_arbiter
// Purpose  : Directed and random stimulus against a behavioural event model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_proc_input_arbiter;
    localparam int MS = 6;
    localparam int TO = 10;
`ifdef PROC_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en_proc = 1'b0;
    logic [1:0]    start = 2'd0;
    logic [5:0]    n1 = 6'd0, n2 = 6'd0, n3 = 6'd0;
    logic [MS+1:0] read_add_1, read_add_2, read_add_3;
    logic          rd_en_1, rd_en_2, rd_en_3;
    logic [1:0]    sel, done;
    logic          valid, busy, truncated;

    always #5 clk = ~clk;

    proc_input_arbiter #(.MEM_SIZE(MS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .en_proc(en_proc), .start(start),
        .number_in_1(n1), .number_in_2(n2), .number_in_3(n3),
        .read_add_1(read_add_1), .read_add_2(read_add_2), .read_add_3(read_add_3),
        .rd_en_1(rd_en_1), .rd_en_2(rd_en_2), .rd_en_3(rd_en_3),
        .sel(sel), .valid(valid), .done(done), .busy(busy), .truncated(truncated)
    );

    int total = 0;
    int bad   = 0;

    // Model: phase 0 idle, 1 running an event, 2 one-cycle drain.
    int m_phase, m_page, m_last, m_startq, m_cyc;
    int m_rem [1:3];
    int m_idx [1:3];
    int m_rd  [1:3];
    int m_addr[1:3];
    int m_valid, m_sel, m_done, m_trunc;

    int log_src[$];
    int log_addr[$];
    int vcount, tcount;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int prev, src, cand, left;
        if (reset) begin
            m_phase = 0; m_page = 0; m_last = 0; m_startq = 0; m_cyc = 0;
            m_valid = 0; m_sel = 0; m_done = 0; m_trunc = 0;
            for (int n = 1; n <= 3; n++) begin
                m_rem[n] = 0; m_idx[n] = 0; m_rd[n] = 0; m_addr[n] = 0;
            end
            return;
        end
        prev = 0;
        for (int n = 1; n <= 3; n++) if (m_rd[n] != 0) prev = n;
        m_valid = (prev != 0);
        m_sel   = prev;
        for (int n = 1; n <= 3; n++) m_rd[n] = 0;
        m_trunc = 0;
        if (int'(start) != m_startq) begin
            if (m_phase != 0) m_done = m_page;
            m_startq = start;
            m_phase  = 1;
            m_page   = start;
            m_last   = 0;
            m_cyc    = 0;
            m_rem[1] = n1; m_rem[2] = n2; m_rem[3] = n3;
            for (int n = 1; n <= 3; n++) m_idx[n] = 0;
        end else if (m_phase == 2) begin
            m_done  = m_page;
            m_phase = 0;
        end else if (m_phase == 1) begin
            if (en_proc) begin
                m_cyc++;
                src = 0;
                for (int k = 1; k <= 3; k++) begin
                    cand = m_last + k;
                    while (cand > 3) cand -= 3;
                    if (src == 0 && m_rem[cand] > 0) src = cand;
                end
                if (src != 0) begin
                    m_rd[src]   = 1;
                    m_addr[src] = m_page * (1 << MS) + m_idx[src];
                    m_idx[src]++;
                    m_rem[src]--;
                    m_last = src;
                end
            end
            left = m_rem[1] + m_rem[2] + m_rem[3];
            if (left == 0) begin
                m_phase = 2;
            end else if (TO_EN && en_proc && m_cyc >= TO) begin
                m_phase = 2;
                m_trunc = 1;
                for (int n = 1; n <= 3; n++) m_rem[n] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("rd_en_1", rd_en_1, m_rd[1]);
        check("rd_en_2", rd_en_2, m_rd[2]);
        check("rd_en_3", rd_en_3, m_rd[3]);
        check("read_add_1", read_add_1, m_addr[1]);
        check("read_add_2", read_add_2, m_addr[2]);
        check("read_add_3", read_add_3, m_addr[3]);
        check("valid", valid, m_valid);
        check("sel", sel, m_sel);
        check("done", done, m_done);
        check("busy", busy, int'(m_phase != 0));
        check("truncated", truncated, m_trunc);
        check("rd_onehot", int'($countones({rd_en_1, rd_en_2, rd_en_3}) <= 1), 1);
        if (rd_en_1) begin log_src.push_back(1); log_addr.push_back(read_add_1); end
        if (rd_en_2) begin log_src.push_back(2); log_addr.push_back(read_add_2); end
        if (rd_en_3) begin log_src.push_back(3); log_addr.push_back(read_add_3); end
        if (valid) vcount++;
        if (truncated) tcount++;
    endtask

    task automatic clear_log();
        log_src.delete();
        log_addr.delete();
        vcount = 0;
        tcount = 0;
    endtask

    task automatic set_event(input int st, input int a, input int b, input int c);
        start = 2'(st);
        n1 = 6'(a); n2 = 6'(b); n3 = 6'(c);
    endtask

    task automatic wait_reads(input int n, input int maxc);
        int c = 0;
        while (log_src.size() < n && c < maxc) begin
            tick();
            c++;
        end
        check("wait_reads", log_src.size(), n);
    endtask

    initial begin
        int exp_src[6];
        int exp_addr[5];
        clear_log();
        repeat (3) tick();
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        reset = 1'b0;
        tick();

        // Counts 3/0/2 on page 1
        clear_log();
        en_proc = 1'b1;
        set_event(1, 3, 0, 2);
        repeat (10) tick();
        exp_src  = '{1, 3, 1, 3, 1, 0};
        exp_addr = '{64, 64, 65, 65, 66};
        check("a_nreads", log_src.size(), 5);
        for (int i = 0; i < 5 && i < log_src.size(); i++) begin
            check("a_src", log_src[i], exp_src[i]);
            check("a_addr", log_addr[i], exp_addr[i]);
        end
        check("a_valid_count", vcount, 5);
        check("a_done", done, 1);
        check("a_busy_end", busy, 0);

        // Empty event on page 2
        clear_log();
        set_event(2, 0, 0, 0);
        repeat (3) tick();
        check("b_nreads", log_src.size(), 0);
        check("b_valid_count", vcount, 0);
        check("b_done", done, 2);

        // Counts 2/2/2 with a three-cycle stall after the second read
        clear_log();
        set_event(3, 2, 2, 2);
        wait_reads(2, 10);
        en_proc = 1'b0;
        repeat (3) tick();
        check("c_stalled", log_src.size(), 2);
        en_proc = 1'b1;
        repeat (10) tick();
        exp_src = '{1, 2, 3, 1, 2, 3};
        check("c_nreads", log_src.size(), 6);
        for (int i = 0; i < 6 && i < log_src.size(); i++) check("c_src", log_src[i], exp_src[i]);
        check("c_done", done, 3);

        // Reset in the middle of an event
        reset = 1'b1;
        set_event(0, 0, 0, 0);
        tick();
        reset = 1'b0;
        tick();
        clear_log();
        set_event(1, 10, 10, 10);
        wait_reads(4, 10);
        reset = 1'b1;
        tick();
        check("d_rd_en", int'({rd_en_1, rd_en_2, rd_en_3}), 0);
        check("d_valid", valid, 0);
        check("d_sel", sel, 0);
        check("d_done", done, 0);
        check("d_busy", busy, 0);
        check("d_addr1", read_add_1, 0);
        set_event(0, 0, 0, 0);
        tick();
        reset = 1'b0;
        tick();

        // Start change in the middle of a long event
        clear_log();
        set_event(1, 40, 40, 40);
        wait_reads(10, 20);
        set_event(2, 40, 40, 40);
        repeat (5) tick();
        check("e_done_old", done, 1);
        if (log_addr.size() > 10) check("e_first_new", log_addr[10], 2 * 64);
        else check("e_first_new_seen", log_addr.size(), 11);
        repeat (130) tick();
        check("e_done_new", done, 2);

        // Long single-source event: cycle budget if built with the timeout
        clear_log();
        set_event(3, 20, 0, 0);
        repeat (30) tick();
        check("f_nreads", log_src.size(), TO_EN ? 10 : 20);
        check("f_trunc_pulses", tcount, TO_EN ? 1 : 0);
        check("f_done", done, 3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 299) == 0);
            en_proc = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) start = 2'($urandom_range(0, 3));
            n1 = 6'($urandom_range(0, 7));
            n2 = 6'($urandom_range(0, 7));
            n3 = 6'($urandom_range(0, 7));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
